// File: rtl/data_bus_bridge.sv
// -----------------------------------------------------------------------------
// data_bus_bridge
//
// Data-side memory subsystem placed directly after the core's MEM stage.
// It holds the data RAM and a small MMIO window:
//   0xF000_0000 TX_DATA   write pushes wdata[7:0] into the TX FIFO, reads 0
//   0xF000_0004 TX_STATUS {count, overflow, full, empty}; any write clears overflow
//   0xF000_0008 CYCLE     free-running counter; any write loads 0
//   0xF000_000C GPIO      32-bit output register
// Loads are combinational and show the state before the current clock edge.
//
// Ports:
//   clk       core clock, all state changes on the rising edge
//   rst       synchronous active-high reset (RAM contents are kept)
//   addr      byte address from the core (addr[1:0] ignored, word access only)
//   wdata     store data from the core
//   mem_w     store strobe
//   rdata     load data back to the core, combinational from addr
//   tx_data   FIFO head byte
//   tx_valid  FIFO non-empty
//   tx_ready  consumer takes the head byte when tx_valid & tx_ready
//   gpio_out  GPIO output register
// -----------------------------------------------------------------------------
module data_bus_bridge #(
   parameter int RAM_AW  = 10,
   parameter int FIFO_AW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_w,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] gpio_out
);

   localparam int RAM_WORDS = 1 << RAM_AW;
   localparam int DEPTH     = 1 << FIFO_AW;

   // Word addresses (addr[31:2]) of the MMIO registers.
   localparam logic [29:0] TX_DATA_WA   = 30'h3C00_0000;
   localparam logic [29:0] TX_STATUS_WA = 30'h3C00_0001;
   localparam logic [29:0] CYCLE_WA     = 30'h3C00_0002;
   localparam logic [29:0] GPIO_WA      = 30'h3C00_0003;

   localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   // Packs the TX_STATUS read word: count from bit 3 upward, then flags.
   function automatic logic [31:0] pack_status(
      input logic [FIFO_AW:0] cnt,
      input logic             ovf,
      input logic             is_full,
      input logic             is_empty
   );
      logic [31:0] st;
      st                   = 32'h0000_0000;
      st[3 +: FIFO_AW+1]   = cnt;
      st[2]                = ovf;
      st[1]                = is_full;
      st[0]                = is_empty;
      return st;
   endfunction

   // Storage and state.
   logic [31:0]        ram [0:RAM_WORDS-1];
   logic [7:0]         fifo [0:DEPTH-1];
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;
   logic [31:0]        cycle;
   logic [31:0]        gpio;

   // Decode and handshake terms.
   logic              ram_sel;
   logic              tx_sel;
   logic              status_sel;
   logic              cycle_sel;
   logic              gpio_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic              full;
   logic              empty;
   logic              push_req;
   logic              push;
   logic              pop;
   logic              ovf_event;

   // Address decode; upper RAM address bits alias onto the same words.
   always_comb begin
      ram_sel    = (addr[31:28] == 4'h0);
      tx_sel     = (addr[31:2] == TX_DATA_WA);
      status_sel = (addr[31:2] == TX_STATUS_WA);
      cycle_sel  = (addr[31:2] == CYCLE_WA);
      gpio_sel   = (addr[31:2] == GPIO_WA);
      ram_idx    = addr[RAM_AW+1:2];
   end

   // FIFO flags and push/pop qualification. Count never exceeds DEPTH,
   // so its top bit alone means full. A push at full survives only when
   // a pop frees a slot on the same edge.
   always_comb begin
      full      = count[FIFO_AW];
      empty     = (count == {(FIFO_AW+1){1'b0}});
      pop       = ~empty & tx_ready;
      push_req  = mem_w & tx_sel;
      push      = push_req & (~full | pop);
      ovf_event = push_req & full & ~pop;
   end

   // Combinational load data from the pre-edge state.
   always_comb begin
      rdata = 32'h0000_0000;
      if (ram_sel) begin
         rdata = ram[ram_idx];
      end else if (status_sel) begin
         rdata = pack_status(count, overflow, full, empty);
      end else if (cycle_sel) begin
         rdata = cycle;
      end else if (gpio_sel) begin
         rdata = gpio;
      end else begin
         rdata = 32'h0000_0000;
      end
   end

   // Data RAM write port; deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (mem_w && ram_sel) begin
         ram[ram_idx] <= wdata;
      end
   end

   // TX FIFO storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= {FIFO_AW{1'b0}};
         wr_ptr   <= {FIFO_AW{1'b0}};
         count    <= {(FIFO_AW+1){1'b0}};
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo[i] <= 8'h00;
         end
      end else begin
         if (push) begin
            fifo[wr_ptr] <= wdata[7:0];
            wr_ptr       <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // A new overflow wins over a clear on the same edge.
         if (ovf_event) begin
            overflow <= 1'b1;
         end else if (mem_w && status_sel) begin
            overflow <= 1'b0;
         end
      end
   end

   // Free-running cycle counter; a write loads 0 instead of incrementing.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle <= 32'h0000_0000;
      end else if (mem_w && cycle_sel) begin
         cycle <= 32'h0000_0000;
      end else begin
         cycle <= cycle + 32'h0000_0001;
      end
   end

   // GPIO output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio <= 32'h0000_0000;
      end else if (mem_w && gpio_sel) begin
         gpio <= wdata;
      end
   end

   assign tx_data  = fifo[rd_ptr];
   assign tx_valid = ~empty;
   assign gpio_out = gpio;

endmodule

// File: tb/tb_data_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_bus_bridge
//
// Directed bench for data_bus_bridge. Inputs change on the falling clock
// edge; outputs are sampled 1 time unit after a falling edge.
// -----------------------------------------------------------------------------
module tb_data_bus_bridge;

   localparam logic [31:0] A_TX     = 32'hF000_0000;
   localparam logic [31:0] A_STATUS = 32'hF000_0004;
   localparam logic [31:0] A_CYCLE  = 32'hF000_0008;
   localparam logic [31:0] A_GPIO   = 32'hF000_000C;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_w;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] gpio_out;

   int n_checks;
   int n_pass;

   data_bus_bridge #(.RAM_AW(10), .FIFO_AW(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .mem_w    (mem_w),
      .rdata    (rdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .gpio_out (gpio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One store cycle; returns on the following falling edge with mem_w low.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      mem_w = 1'b1;
      @(negedge clk);
      mem_w = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_seq [0:7];
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      addr     = 32'h0000_0000;
      wdata    = 32'h0000_0000;
      mem_w    = 1'b0;
      tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      #1;
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_gpio", gpio_out, 32'd0);
      rd_check("rst_status", A_STATUS, 32'h0000_0001);
      rd_check("rst_cycle", A_CYCLE, 32'd0);

      // RAM round trip, byte offsets ignored, aliasing, non-RAM region.
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      wr(32'h0000_0014, 32'h1234_5678);
      rd_check("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
      rd_check("ram_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
      rd_check("ram_0x14", 32'h0000_0014, 32'h1234_5678);
      rd_check("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
      rd_check("unmapped_1x", 32'h1000_0010, 32'd0);

      // GPIO write is visible right after the edge.
      wr(A_GPIO, 32'hA5A5_0F0F);
      #1;
      check("gpio_out", gpio_out, 32'hA5A5_0F0F);
      rd_check("gpio_read", A_GPIO, 32'hA5A5_0F0F);

      // Cycle counter: 0 the cycle after the write, 5 five cycles later.
      wr(A_CYCLE, 32'hFFFF_FFFF);
      rd_check("cycle_n1", A_CYCLE, 32'd0);
      repeat (5) @(negedge clk);
      rd_check("cycle_n6", A_CYCLE, 32'd5);

      // FIFO fill to full.
      for (int i = 0; i < 8; i++) begin
         wr(A_TX, 32'h0000_0041 + i);
      end
      rd_check("fill_status", A_STATUS, 32'h0000_0042);
      #1;
      check("fill_head", {24'd0, tx_data}, 32'h0000_0041);
      // Ninth push is dropped and flags overflow.
      wr(A_TX, 32'h0000_0049);
      rd_check("ovf_status", A_STATUS, 32'h0000_0046);
      rd_check("tx_data_read", A_TX, 32'd0);
      // Clear overflow.
      wr(A_STATUS, 32'h1234_5678);
      rd_check("ovf_clear", A_STATUS, 32'h0000_0042);

      // Drain in order.
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("drain_%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h41 + 8'(i)});
         @(negedge clk);
      end
      #1;
      check("drain_valid", {31'd0, tx_valid}, 32'd0);
      rd_check("drain_status", A_STATUS, 32'h0000_0001);
      tx_ready = 1'b0;

      // Push and pop at full: both happen, no overflow.
      for (int i = 0; i < 8; i++) begin
         wr(A_TX, 32'h0000_0061 + i);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      addr     = A_TX;
      wdata    = 32'h0000_005A;
      mem_w    = 1'b1;
      @(negedge clk);
      mem_w    = 1'b0;
      tx_ready = 1'b0;
      rd_check("pp_full_status", A_STATUS, 32'h0000_0042);
      exp_seq[0] = 8'h62; exp_seq[1] = 8'h63; exp_seq[2] = 8'h64; exp_seq[3] = 8'h65;
      exp_seq[4] = 8'h66; exp_seq[5] = 8'h67; exp_seq[6] = 8'h68; exp_seq[7] = 8'h5A;
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("pp_drain_%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp_seq[i]});
         @(negedge clk);
      end
      #1;
      check("pp_empty", {31'd0, tx_valid}, 32'd0);
      tx_ready = 1'b0;

      // Reset mid-stream with a pending push and pop in the reset cycle.
      wr(A_TX, 32'h0000_0031);
      wr(A_TX, 32'h0000_0032);
      wr(A_TX, 32'h0000_0033);
      wr(A_GPIO, 32'h0000_1234);
      #1;
      check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
      check("pre_rst_gpio", gpio_out, 32'h0000_1234);
      rd_check("pre_rst_status", A_STATUS, 32'h0000_0018);
      @(negedge clk);
      rst      = 1'b1;
      addr     = A_TX;
      wdata    = 32'h0000_0077;
      mem_w    = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      mem_w    = 1'b0;
      tx_ready = 1'b0;
      #1;
      check("post_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("post_rst_gpio", gpio_out, 32'd0);
      rd_check("post_rst_status", A_STATUS, 32'h0000_0001);
      rd_check("post_rst_cycle", A_CYCLE, 32'd0);
      rd_check("post_rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
      rd_check("unmapped_8x", 32'h8000_0000, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
